serial_tx: RTL and testbench
============================

// Module: serial_tx
// PURPOSE
//  Parallel-to-serial framed transmitter; the outbound counterpart of the rx deserializer in top.
//  Accepts DATA_W-bit words over a valid/ready handshake into a 1-entry holding register.
//  Serializes each word onto tx as start bit, data bits, optional parity bit and stop bit.
//  Bit order is selected per word by l2b.
// PARAMETERS
//  DATA_W       8  data bits per frame (>=1)
//  CLKS_PER_BIT 4  clk cycles per serial bit (>=2)
// PORTS
//  clk       in   1       single clock; all logic on posedge
//  rst       in   1       synchronous, active-high reset
//  tx_data   in   DATA_W  word to send
//  tx_l2b    in   1       1: LSB first; 0: MSB first. Captured with tx_data
//  tx_valid  in   1       word offered
//  tx_ready  out  1       holding register empty; a word is accepted on posedge when tx_valid & tx_ready
//  tx        out  1       serial line; idle high
//  busy      out  1       frame in progress (state != IDLE)
//  tx_done   out  1       1-cycle pulse in the last clk of each stop bit
// BEHAVIOUR
//  Reset: tx=1, busy=0, tx_done=0, holding register empty, FSM=IDLE, baud/bit counters=0.
//   tx_ready=0 while rst=1, and 1 in the first cycle after rst deasserts.
//  tx_ready = !rst & !hold_full (combinational).
//  Accept: on the edge where tx_valid & tx_ready, {tx_data, tx_l2b} go into hold and hold_full=1.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE|START. Every non-IDLE state
//   lasts exactly CLKS_PER_BIT cycles; the baud counter runs 0..CLKS_PER_BIT-1 and clears on
//   each state/bit change.
//  IDLE: tx=1. If hold_full, next edge loads shifter from hold, clears hold_full, enters START.
//   Latency: tx goes low 1 cycle after the accepting edge when the FSM is idle.
//  START: tx=0. DATA: tx=current shifter bit. DATA_W bits are sent, bit counter 0..DATA_W-1,
//   order per captured l2b.
//  STOP: tx=1. In its last cycle tx_done=1. If hold_full then, the next edge goes straight to
//   START (no idle gap between frames). Otherwise it goes to IDLE.
//  Simultaneous: hold drains to shifter and a new word is accepted on the same edge ->
//   hold_full stays 1 with the new word. This cannot happen while hold_full=1 because
//   ready=0, so a word is never lost or overwritten.
//  tx_valid dropping without acceptance has no effect. tx_data/tx_l2b are don't-care when not accepted.
//  Reset mid-frame: frame aborted; the next cycle shows tx=1, busy=0, hold cleared, and the
//   held word discarded.
//  Frame length: (DATA_W+2)*CLKS_PER_BIT clk, or (DATA_W+3)*CLKS_PER_BIT clk with parity.
//  tx is driven from a register (glitch-free).
// CONFIGURATION
//  SERIAL_TX_PARITY_EN defined:
//   - PARITY state is inserted after DATA.
//   - tx = even parity (XOR of the DATA_W data bits) for CLKS_PER_BIT cycles.
//  Not defined:
//   - no PARITY state; DATA goes directly to STOP.
//   - no parity logic is synthesized.
// TESTING (DATA_W=8, CLKS_PER_BIT=4, parity off unless noted)
//  1 Hold rst 3 clk, then release -> tx=1, busy=0, tx_done=0 throughout; tx_ready 0 during rst, 1 after.
//  2 Send 0x13, l2b=1 -> tx: 0 x4, then bits 1,1,0,0,1,0,0,0 (4 clk each), then 1 x4.
//    tx_done pulses once at clk 40 of the frame; busy high 40 clk.
//  3 Send 0x13, l2b=0 -> data bits 0,0,0,1,0,0,1,1; start/stop framing as in test 2.
//  4 Hold tx_valid with 0x13 then 0xFF (l2b=1):
//    - 0xFF is accepted during frame 1;
//    - tx_ready stays 0 until frame 2 START;
//    - frame 2 start bit follows frame 1 stop bit with no idle cycle;
//    - two tx_done pulses 40 clk apart.
//  5 Assert rst for 1 clk during DATA bit 3 with a second word held ->
//    tx=1 and busy=0 next cycle, no further frame, no tx_done pulse.
//  6 With SERIAL_TX_PARITY_EN: send 0x13, l2b=1 -> parity bit 1 after data, then stop; frame 44 clk.
//    Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/serial_tx.sv
// Framed parallel-to-serial transmitter: start bit, DATA_W data bits, optional parity, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_l2b,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [BW-1:0]     bitn, bit_nxt;
   logic [DATA_W-1:0] sh, sh_nxt;
   logic              l2b, l2b_nxt;
   logic [DATA_W-1:0] hold_data;
   logic              hold_l2b;
   logic              hold_full;
   logic              accept, load, last, tx_nxt;
`ifdef SERIAL_TX_PARITY_EN
   logic              par, par_nxt;
`endif

   assign tx_ready = !rst && !hold_full;
   assign accept   = tx_valid && tx_ready;
   assign busy     = (state != IDLE);
   assign last     = (cnt == CNT_LAST);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      bit_nxt   = bitn;
      sh_nxt    = sh;
      l2b_nxt   = l2b;
      load      = 1'b0;
      tx_done   = 1'b0;
      tx_nxt    = 1'b1;
      if (state != IDLE)
         cnt_nxt = last ? '0 : cnt + CW'(1);
      case (state)
         IDLE: if (hold_full) begin
            load      = 1'b1;
            state_nxt = START;
         end
         START: if (last) begin
            state_nxt = DATA;
            bit_nxt   = '0;
         end
         DATA: if (last) begin
            if (bitn == BIT_LAST)
`ifdef SERIAL_TX_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = STOP;
`endif
            else begin
               bit_nxt = bitn + BW'(1);
               sh_nxt  = l2b ? (sh >> 1) : (sh << 1);
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: if (last) state_nxt = STOP;
`endif
         STOP: begin
            tx_done = last;
            // a held word chains straight into the next start bit
            if (last) begin
               if (hold_full) begin
                  load      = 1'b1;
                  state_nxt = START;
               end else
                  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (load) begin
         sh_nxt  = hold_data;
         l2b_nxt = hold_l2b;
      end
`ifdef SERIAL_TX_PARITY_EN
      par_nxt = load ? ^hold_data : par;
`endif
      // tx is registered from the next-state view so the line changes on the state edge
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = l2b_nxt ? sh_nxt[0] : sh_nxt[DATA_W-1];
`ifdef SERIAL_TX_PARITY_EN
         PARITY:  tx_nxt = par_nxt;
`endif
         default: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bitn      <= '0;
         sh        <= '0;
         l2b       <= 1'b0;
         hold_data <= '0;
         hold_l2b  <= 1'b0;
         hold_full <= 1'b0;
         tx        <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         bitn  <= bit_nxt;
         sh    <= sh_nxt;
         l2b   <= l2b_nxt;
         tx    <= tx_nxt;
         if (accept) begin
            hold_data <= tx_data;
            hold_l2b  <= tx_l2b;
            hold_full <= 1'b1;
         end else if (load)
            hold_full <= 1'b0;
      end
   end

`ifdef SERIAL_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) par <= 1'b0;
      else     par <= par_nxt;
   end
`endif

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: a cycle-timeline model schedules each accepted word's
// frame and every cycle's tx/busy/tx_done/tx_ready is compared against that timeline.
module tb_serial_tx;

   localparam int DW   = 8;
   localparam int CPB  = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int FLEN = (DW + 3) * CPB;
`else
   localparam int FLEN = (DW + 2) * CPB;
`endif
   localparam int NCYC = 6000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] tx_data = '0;
   logic          tx_l2b = 1'b0;
   logic          tx_valid = 1'b0;
   logic          tx_ready, tx, busy, tx_done;

   serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_l2b(tx_l2b), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx(tx), .busy(busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   bit exp_tx[NCYC], exp_busy[NCYC], exp_done[NCYC], exp_rdy[NCYC];
   int cyc = 0, prev_end = -10, last_start = 0;
   int ncmp = 0, nfail = 0;

   task automatic chk(input string tag, input logic obs, input logic exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic clear_from(input int c);
      for (int i = c; i < NCYC; i++) begin
         exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_rdy[i] = 1'b1;
      end
      prev_end = -10;
   endtask

   // Word accepted on the edge ending cycle c: held for a cycle, then its frame runs
   // after any frame already in flight.
   task automatic schedule(input int c, input logic [DW-1:0] d, input bit l);
      bit bits[$];
      int start, idx;
      start = (prev_end + 1 > c + 2) ? prev_end + 1 : c + 2;
      if (start + FLEN >= NCYC) begin
         nfail++;
         $display("FAIL timeline_overflow start=%0d required<%0d", start + FLEN, NCYC);
         return;
      end
      for (int i = c + 1; i < start; i++) exp_rdy[i] = 1'b0;
      bits.push_back(1'b0);
      for (int k = 0; k < DW; k++) bits.push_back(l ? d[k] : d[DW-1-k]);
`ifdef SERIAL_TX_PARITY_EN
      bits.push_back(^d);
`endif
      bits.push_back(1'b1);
      for (int j = 0; j < bits.size(); j++)
         for (int q = 0; q < CPB; q++) begin
            idx = start + j * CPB + q;
            exp_tx[idx] = bits[j];
            exp_busy[idx] = 1'b1;
         end
      exp_done[start + FLEN - 1] = 1'b1;
      prev_end   = start + FLEN - 1;
      last_start = start;
   endtask

   // One clock cycle: drive inputs just after posedge, check at negedge.
   task automatic cycle(input bit r, input bit v, input logic [DW-1:0] d, input bit l,
                        output bit acc);
      rst = r; tx_valid = v; tx_data = d; tx_l2b = l;
      if (r) begin
         exp_rdy[cyc] = 1'b0;
         clear_from(cyc + 1);
      end
      @(negedge clk);
      chk("tx", tx, exp_tx[cyc]);
      chk("busy", busy, exp_busy[cyc]);
      chk("tx_done", tx_done, exp_done[cyc]);
      chk("tx_ready", tx_ready, exp_rdy[cyc]);
      acc = v && exp_rdy[cyc];
      if (acc) schedule(cyc, d, l);
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      bit acc;
      repeat (n) cycle(1'b0, 1'b0, DW'($urandom), 1'($urandom), acc);
   endtask

   task automatic send(input logic [DW-1:0] d, input bit l);
      bit acc;
      int tries = 0;
      acc = 1'b0;
      while (!acc && tries < 3 * FLEN) begin
         cycle(1'b0, 1'b1, d, l, acc);
         tries++;
      end
      if (!acc) begin
         nfail++;
         $display("FAIL send_timeout data=%h waited=%0d cycles required<%0d", d, tries, 3 * FLEN);
      end
   endtask

   initial begin
      bit acc;
      int a_start;
      clear_from(0);
      @(posedge clk); #1;

      // reset held 3 clocks, then idle line
      repeat (3) cycle(1'b1, 1'b0, '0, 1'b0, acc);
      idle(3);

      // single frames in both bit orders
      send(8'h13, 1'b1); idle(FLEN + 5);
      send(8'h13, 1'b0); idle(FLEN + 5);
      send(8'h03, 1'b1); idle(FLEN + 5);

      // back-to-back: valid held across two words
      send(8'h13, 1'b1);
      send(8'hFF, 1'b1);
      idle(2 * FLEN + 5);

      // reset during data bit 3 with a second word held
      send(8'hA5, 1'b1);
      a_start = last_start;
      send(8'h5A, 1'b0);
      while (cyc < a_start + 4 * CPB + 1) idle(1);
      cycle(1'b1, 1'b0, '0, 1'b0, acc);
      idle(FLEN + 10);

      // randomized words, gaps and bit order
      for (int n = 0; n < 24; n++) begin
         idle($urandom_range(0, FLEN));
         send(DW'($urandom), 1'($urandom));
      end
      idle(2 * FLEN + 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
